// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution job sequencer: FSM states, register
// map offsets, control-register values and the address helper.
package conv_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_CFG1   = 4'd1,
    S_WR_CFG2   = 4'd2,
    S_WR_START  = 4'd3,
    S_POLL_RD   = 4'd4,
    S_POLL_GAP  = 4'd5,
    S_DONE_WAIT = 4'd6,
    S_CLR_START = 4'd7,
    S_SRST_SET  = 4'd8,
    S_SRST_CLR  = 4'd9
  } seq_state_e;

  localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
  localparam logic [31:0] OFF_CFG1   = 32'h0000_0004;
  localparam logic [31:0] OFF_CFG2   = 32'h0000_0008;

  localparam logic [31:0] CTRL_START = 32'h0000_0004;
  localparam logic [31:0] CTRL_SRST  = 32'h0000_0002;

  localparam int DONE_BIT = 0;

  // Instance n lives at base + (n << 24); the sum wraps at 32 bits.
  function automatic logic [31:0] inst_reg_addr(input logic [31:0] base,
                                                input logic [7:0]  inst,
                                                input logic [31:0] off);
    return base + ({24'd0, inst} << 24) + off;
  endfunction

endpackage

// File: rtl/conv_job_sequencer_wb_master.sv
// Single-transaction Wishbone master: latches one request, holds the bus
// until ack, and reports completion combinationally on the ack cycle.
module wb_single_master
  import conv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_w,
  input  logic        wb_ack,
  input  logic [31:0] wb_dat_r
);

  logic        cyc_reg;
  logic        we_reg;
  logic [3:0]  sel_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cyc_reg   <= 1'b0;
      we_reg    <= 1'b0;
      sel_reg   <= 4'h0;
      adr_reg   <= 32'h0;
      dat_reg   <= 32'h0;
      rdata_reg <= 32'h0;
    end else if (cyc_reg) begin
      if (wb_ack) begin
        cyc_reg   <= 1'b0;
        we_reg    <= 1'b0;
        sel_reg   <= 4'h0;
        rdata_reg <= wb_dat_r;
      end
    end else if (req) begin
      cyc_reg <= 1'b1;
      we_reg  <= we;
      sel_reg <= 4'hF;
      adr_reg <= adr;
      dat_reg <= dat;
    end
  end

  // Completion is flagged in the ack cycle so the caller can advance on the
  // same edge; rdata bypasses the capture register during that cycle.
  assign done     = cyc_reg & wb_ack;
  assign rdata    = done ? wb_dat_r : rdata_reg;
  assign busy     = cyc_reg;
  assign wb_cyc   = cyc_reg;
  assign wb_stb   = cyc_reg;
  assign wb_we    = we_reg;
  assign wb_sel   = sel_reg;
  assign wb_adr   = adr_reg;
  assign wb_dat_w = dat_reg;

endmodule

// File: rtl/conv_job_sequencer.sv
// Job sequencer: programs one accelerator instance over Wishbone, starts it,
// polls for done, waits for host release, then clears start and soft-resets.
module conv_job_sequencer
  import conv_seq_pkg::*;
#(
  parameter int          NO_OF_INSTS    = 4,
  parameter logic [31:0] REG_BASE_ADDR  = 32'h3000_0000,
  parameter int          POLL_GAP       = 10,
  parameter int          POLL_MAX       = 100,
  parameter int          POLL_CNT_WIDTH = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      job_valid_i,
  output logic                      job_ready_o,
  input  logic [7:0]                job_inst_i,
  input  logic [31:0]               job_cfg1_i,
  input  logic [31:0]               job_cfg2_i,
  input  logic                      job_release_i,
  output logic                      busy_o,
  output logic                      job_done_o,
  output logic                      job_err_o,
  output logic [POLL_CNT_WIDTH-1:0] poll_cnt_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [3:0]                wbm_sel_o,
  output logic [31:0]               wbm_adr_o,
  output logic [31:0]               wbm_dat_o,
  input  logic                      wbm_ack_i,
  input  logic [31:0]               wbm_dat_i
);

  seq_state_e                state_reg;
  logic [7:0]                inst_reg;
  logic [31:0]               cfg1_reg;
  logic [31:0]               cfg2_reg;
  logic                      issued_reg;
  logic                      inv_reg;
  logic                      err_reg;
  logic [POLL_CNT_WIDTH-1:0] poll_cnt_reg;
  logic [7:0]                gap_cnt_reg;

  logic        req;
  logic        req_we;
  logic        in_txn;
  logic [31:0] req_off;
  logic [31:0] req_dat;
  logic [31:0] req_adr;
  logic        mst_busy;
  logic        mst_done;
  logic [31:0] mst_rdata;
  logic        unused_rdata;

  always_comb begin
    in_txn  = 1'b1;
    req_we  = 1'b1;
    req_off = OFF_CTRL;
    req_dat = 32'h0;
    case (state_reg)
      S_WR_CFG1:   begin req_off = OFF_CFG1; req_dat = cfg1_reg; end
      S_WR_CFG2:   begin req_off = OFF_CFG2; req_dat = cfg2_reg; end
      S_WR_START:  req_dat = CTRL_START;
      S_POLL_RD:   req_we  = 1'b0;
      S_CLR_START: req_dat = 32'h0;
      S_SRST_SET:  req_dat = CTRL_SRST;
      S_SRST_CLR:  req_dat = 32'h0;
      default: begin
        in_txn = 1'b0;
        req_we = 1'b0;
      end
    endcase
    req_adr = inst_reg_addr(REG_BASE_ADDR, inst_reg, req_off);
  end

  // One request per transaction state; issued_reg blocks re-issue until ack.
  assign req = in_txn & ~issued_reg & ~mst_busy;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= S_IDLE;
      inst_reg     <= 8'h0;
      cfg1_reg     <= 32'h0;
      cfg2_reg     <= 32'h0;
      issued_reg   <= 1'b0;
      inv_reg      <= 1'b0;
      err_reg      <= 1'b0;
      poll_cnt_reg <= '0;
      gap_cnt_reg  <= 8'h0;
    end else begin
      if (req)      issued_reg <= 1'b1;
      if (mst_done) issued_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (job_valid_i) begin
            inst_reg     <= job_inst_i;
            cfg1_reg     <= job_cfg1_i;
            cfg2_reg     <= job_cfg2_i;
            poll_cnt_reg <= '0;
            if (32'(job_inst_i) >= NO_OF_INSTS) begin
              err_reg   <= 1'b1;
              inv_reg   <= 1'b1;
              state_reg <= S_DONE_WAIT;
            end else begin
              err_reg   <= 1'b0;
              inv_reg   <= 1'b0;
              state_reg <= S_WR_CFG1;
            end
          end
        end
        S_WR_CFG1:  if (mst_done) state_reg <= S_WR_CFG2;
        S_WR_CFG2:  if (mst_done) state_reg <= S_WR_START;
        S_WR_START: if (mst_done) state_reg <= S_POLL_RD;
        S_POLL_RD: begin
          if (req) poll_cnt_reg <= poll_cnt_reg + POLL_CNT_WIDTH'(1);
          if (mst_done) begin
            gap_cnt_reg <= 8'h0;
            if (mst_rdata[DONE_BIT]) begin
              state_reg <= S_DONE_WAIT;
            end else if (poll_cnt_reg == POLL_CNT_WIDTH'(POLL_MAX)) begin
              err_reg   <= 1'b1;
              state_reg <= S_DONE_WAIT;
            end else begin
              state_reg <= (POLL_GAP > 1) ? S_POLL_GAP : S_POLL_RD;
            end
          end
        end
        // The request cycle of the next poll is itself idle on the bus, so
        // POLL_GAP-1 cycles here give POLL_GAP idle bus cycles between polls.
        S_POLL_GAP: begin
          if (gap_cnt_reg == 8'(POLL_GAP - 2)) state_reg <= S_POLL_RD;
          else gap_cnt_reg <= gap_cnt_reg + 8'd1;
        end
        S_DONE_WAIT: begin
          if (job_release_i) begin
            err_reg   <= 1'b0;
            state_reg <= inv_reg ? S_IDLE : S_CLR_START;
          end
        end
        S_CLR_START: if (mst_done) state_reg <= S_SRST_SET;
        S_SRST_SET:  if (mst_done) state_reg <= S_SRST_CLR;
        S_SRST_CLR:  if (mst_done) state_reg <= S_IDLE;
        default:     state_reg <= S_IDLE;
      endcase
    end
  end

  wb_single_master u_wb_master (
    .clk      (wb_clk_i),
    .srst     (wb_rst_i),
    .req      (req),
    .we       (req_we),
    .adr      (req_adr),
    .dat      (req_dat),
    .busy     (mst_busy),
    .done     (mst_done),
    .rdata    (mst_rdata),
    .wb_cyc   (wbm_cyc_o),
    .wb_stb   (wbm_stb_o),
    .wb_we    (wbm_we_o),
    .wb_sel   (wbm_sel_o),
    .wb_adr   (wbm_adr_o),
    .wb_dat_w (wbm_dat_o),
    .wb_ack   (wbm_ack_i),
    .wb_dat_r (wbm_dat_i)
  );

  // Only the done flag of the status word matters to the sequencer.
  assign unused_rdata = ^mst_rdata;

  assign job_ready_o = (state_reg == S_IDLE);
  assign busy_o      = (state_reg != S_IDLE);
  assign job_done_o  = (state_reg == S_DONE_WAIT);
  assign job_err_o   = err_reg;
  assign poll_cnt_o  = poll_cnt_reg;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed self-checking bench for conv_job_sequencer with a Wishbone slave
// model (configurable wait states, done after N polls) and a bus logger.
module tb_conv_job_sequencer;

  logic        clk = 1'b0;
  logic        srst;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_inst;
  logic [31:0] job_cfg1;
  logic [31:0] job_cfg2;
  logic        job_release;
  logic        busy;
  logic        job_done;
  logic        job_err;
  logic [7:0]  poll_cnt;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_w, wbm_dat_r;

  int checks = 0;
  int errors = 0;

  // Slave model controls (written only by the stimulus process)
  int ws = 0;
  int done_after = 0;
  int rd_base = 0;

  // Monitor state
  int cyc_n = 0;
  int cyc_hi = 0;
  int n_tx = 0;
  int rd_cnt = 0;
  int stab_err = 0;
  int idle_run = 0;
  int wcnt = 0;
  int cur_start = 0;
  bit in_txn = 1'b0;
  logic [31:0] h_adr, h_dat;
  logic        h_we;
  logic [3:0]  h_sel;
  logic        log_we  [512];
  logic [31:0] log_adr [512];
  logic [31:0] log_dat [512];
  int          tx_start[512];
  int          rd_gap  [512];

  always #5 clk = ~clk;

  conv_job_sequencer dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (srst),
    .job_valid_i   (job_valid),
    .job_ready_o   (job_ready),
    .job_inst_i    (job_inst),
    .job_cfg1_i    (job_cfg1),
    .job_cfg2_i    (job_cfg2),
    .job_release_i (job_release),
    .busy_o        (busy),
    .job_done_o    (job_done),
    .job_err_o     (job_err),
    .poll_cnt_o    (poll_cnt),
    .wbm_cyc_o     (wbm_cyc),
    .wbm_stb_o     (wbm_stb),
    .wbm_we_o      (wbm_we),
    .wbm_sel_o     (wbm_sel),
    .wbm_adr_o     (wbm_adr),
    .wbm_dat_o     (wbm_dat_w),
    .wbm_ack_i     (wbm_ack),
    .wbm_dat_i     (wbm_dat_r)
  );

  // Slave: ack after ws wait states; status bit 0 set from the done_after-th
  // poll of the current job, other bits noisy to expose wrong-bit decoding.
  assign wbm_ack   = wbm_cyc & wbm_stb & (wcnt == ws);
  assign wbm_dat_r = (done_after != 0 && (rd_cnt - rd_base + 1) >= done_after)
                     ? 32'h0000_0001 : 32'hFFFF_FFFE;

  always @(posedge clk) begin
    if (wbm_stb && !wbm_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  always @(posedge clk) begin
    cyc_n = cyc_n + 1;
    if (wbm_cyc) cyc_hi = cyc_hi + 1;
    if (!wbm_stb) begin
      in_txn   = 1'b0;
      idle_run = idle_run + 1;
    end else begin
      if (!in_txn) begin
        in_txn    = 1'b1;
        h_adr     = wbm_adr;
        h_dat     = wbm_dat_w;
        h_we      = wbm_we;
        h_sel     = wbm_sel;
        cur_start = cyc_n;
        if (!wbm_we) rd_gap[rd_cnt] = idle_run;
        idle_run  = 0;
      end else if (wbm_adr !== h_adr || wbm_dat_w !== h_dat ||
                   wbm_we !== h_we || wbm_sel !== h_sel) begin
        stab_err = stab_err + 1;
      end
      if (wbm_ack) begin
        log_we[n_tx]   = wbm_we;
        log_adr[n_tx]  = wbm_adr;
        log_dat[n_tx]  = wbm_we ? wbm_dat_w : wbm_dat_r;
        tx_start[n_tx] = cur_start;
        $display("TX %0d %s adr=%h dat=%h sel=%h start=%0d", n_tx,
                 wbm_we ? "WR" : "RD", wbm_adr, log_dat[n_tx], wbm_sel, cur_start);
        if (!wbm_we) rd_cnt <= rd_cnt + 1;
        n_tx   = n_tx + 1;
        in_txn = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic submit(input logic [7:0] inst, input logic [31:0] c1, input logic [31:0] c2);
    @(negedge clk);
    job_valid = 1'b1;
    job_inst  = inst;
    job_cfg1  = c1;
    job_cfg2  = c2;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic pulse_release();
    @(negedge clk);
    job_release = 1'b1;
    @(negedge clk);
    job_release = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i;
    for (i = 0; i < bound && !job_done; i++) @(negedge clk);
    if (!job_done) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int i;
    for (i = 0; i < bound && !job_ready; i++) @(negedge clk);
    if (!job_ready) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int hold_tx;
    int hold_hi;
    srst = 1'b1; job_valid = 1'b0; job_inst = 8'h0; job_cfg1 = 32'h0;
    job_cfg2 = 32'h0; job_release = 1'b0;

    // Reset with a valid descriptor present: reset wins, nothing accepted
    @(negedge clk);
    job_valid = 1'b1;
    @(negedge clk);
    srst = 1'b0; job_valid = 1'b0;
    check("rst_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", job_done, 0);
    check("rst_err", job_err, 0);
    check("rst_poll", poll_cnt, 0);
    check("rst_cyc", wbm_cyc, 0);
    check("rst_stb", wbm_stb, 0);
    check("rst_we", wbm_we, 0);
    check("rst_sel", wbm_sel, 0);
    check("rst_adr", wbm_adr, 0);
    check("rst_dat", wbm_dat_w, 0);

    // Happy path, done on third poll
    b = n_tx; rd_base = rd_cnt; done_after = 3; ws = 0;
    submit(8'd0, 32'h0101_5501, 32'h0002_022A);
    check("hp_stb_accept", wbm_stb, 0);
    check("hp_busy", busy, 1);
    @(negedge clk);
    check("hp_stb_first", wbm_stb, 1);
    check("hp_adr_first", wbm_adr, 32'h3000_0004);
    wait_done("hp_wait_done", 500);
    check("hp_ntx", n_tx - b, 6);
    check("hp_w0_adr", log_adr[b], 32'h3000_0004);
    check("hp_w0_dat", log_dat[b], 32'h0101_5501);
    check("hp_w1_adr", log_adr[b+1], 32'h3000_0008);
    check("hp_w1_dat", log_dat[b+1], 32'h0002_022A);
    check("hp_w2_adr", log_adr[b+2], 32'h3000_0000);
    check("hp_w2_dat", log_dat[b+2], 32'h0000_0004);
    check("hp_w2_we", log_we[b+2], 1);
    check("hp_r_we", log_we[b+3], 0);
    check("hp_r_adr", log_adr[b+5], 32'h3000_0000);
    check("hp_poll", poll_cnt, 3);
    check("hp_done", job_done, 1);
    check("hp_err", job_err, 0);
    check("hp_ready_busy", job_ready, 0);
    repeat (5) @(negedge clk);
    check("hp_hold_ntx", n_tx - b, 6);
    check("hp_hold_cyc", wbm_cyc, 0);
    pulse_release();
    wait_ready("hp_wait_ready", 200);
    check("hp_cl_ntx", n_tx - b, 9);
    check("hp_c0_adr", log_adr[b+6], 32'h3000_0000);
    check("hp_c0_dat", log_dat[b+6], 32'h0);
    check("hp_c1_dat", log_dat[b+7], 32'h2);
    check("hp_c2_dat", log_dat[b+8], 32'h0);
    check("hp_c2_we", log_we[b+8], 1);
    check("hp_post_done", job_done, 0);
    check("hp_post_busy", busy, 0);

    // Instance 2, early release ignored, poll spacing
    b = n_tx; rd_base = rd_cnt; done_after = 2;
    submit(8'd2, 32'h0000_000A, 32'h0000_000B);
    pulse_release();
    wait_done("i2_wait_done", 500);
    check("i2_ntx", n_tx - b, 5);
    for (int k = 0; k < 5; k++) check("i2_adr_hi", log_adr[b+k] >> 8, 32'h0032_0000);
    check("i2_poll_gap", rd_gap[rd_base+1], 10);
    check("i2_poll", poll_cnt, 2);
    pulse_release();
    wait_ready("i2_wait_ready", 200);
    check("i2_cl_adr", log_adr[b+7], 32'h3200_0000);

    // Timeout: done never reported
    b = n_tx; rd_base = rd_cnt; done_after = 0;
    submit(8'd1, 32'h1, 32'h2);
    wait_done("to_wait_done", 3000);
    check("to_reads", rd_cnt - rd_base, 100);
    check("to_poll", poll_cnt, 100);
    check("to_err", job_err, 1);
    check("to_done", job_done, 1);
    pulse_release();
    check("to_err_clr", job_err, 0);
    wait_ready("to_wait_ready", 200);
    check("to_ntx", n_tx - b, 106);
    check("to_last_adr", log_adr[b+105], 32'h3100_0000);
    check("to_last_dat", log_dat[b+105], 32'h0);

    // Invalid instance: no bus traffic, second descriptor refused
    b = n_tx; hold_hi = cyc_hi;
    submit(8'd4, 32'h5, 32'h6);
    check("inv_err", job_err, 1);
    check("inv_done", job_done, 1);
    check("inv_poll", poll_cnt, 0);
    job_valid = 1'b1; job_inst = 8'd0;
    repeat (4) @(negedge clk);
    check("inv_ready", job_ready, 0);
    check("inv_still_done", job_done, 1);
    job_valid = 1'b0;
    pulse_release();
    check("inv_ready_rel", job_ready, 1);
    check("inv_err_clr", job_err, 0);
    check("inv_ntx", n_tx - b, 0);
    check("inv_cyc_hi", cyc_hi - hold_hi, 0);

    // Wait states: 5-cycle transactions, signals held stable
    b = n_tx; rd_base = rd_cnt; done_after = 1; ws = 3; stab_err = 0;
    submit(8'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done("ws_wait_done", 500);
    check("ws_adr0", log_adr[b], 32'h3300_0004);
    check("ws_len0", tx_start[b+1] - tx_start[b], 5);
    check("ws_len1", tx_start[b+2] - tx_start[b+1], 5);
    check("ws_len2", tx_start[b+3] - tx_start[b+2], 5);
    check("ws_stable", stab_err, 0);
    pulse_release();
    wait_ready("ws_wait_ready", 200);
    check("ws_ntx", n_tx - b, 7);

    // Reset during WR_CFG2 abandons the job
    b = n_tx;
    submit(8'd0, 32'h7, 32'h8);
    for (int i = 0; i < 100 && !(n_tx == b + 1 && wbm_stb); i++) @(negedge clk);
    check("rs_in_cfg2", wbm_stb && (n_tx == b + 1), 1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("rs_cyc", wbm_cyc, 0);
    check("rs_stb", wbm_stb, 0);
    check("rs_ready", job_ready, 1);
    check("rs_busy", busy, 0);
    hold_tx = n_tx; hold_hi = cyc_hi;
    repeat (30) @(negedge clk);
    check("rs_no_tx", n_tx - hold_tx, 0);
    check("rs_no_cyc", cyc_hi - hold_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
